// File: rtl/free_list_pkg.sv
// Shared rename-path types and sizes for the free list.
// Tag width, ring pointer width and the dispatch-stage packet.
package free_list_pkg;

    localparam int PHYS_REG_SZ = 64;
    localparam int ARCH_REG_SZ = 32;
    localparam int FL_SZ = PHYS_REG_SZ - ARCH_REG_SZ;

    localparam int TAG_W = $clog2(PHYS_REG_SZ);
    localparam int PTR_W = $clog2(FL_SZ);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        tag_t T;
        logic valid;
    } fl_packet_t;

    function automatic fl_packet_t fl_packet(
        input tag_t t,
        input logic v
    );
        fl_packet_t p;
        p.T = t;
        p.valid = v;
        return p;
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch/retire/flush bundle between the rename logic and the free list.
// master drives requests; slave is the free list itself.
interface free_list_if
    import free_list_pkg::*;
#(
    parameter int PHYS_REG_SZ = free_list_pkg::PHYS_REG_SZ,
    parameter int FL_SZ = free_list_pkg::FL_SZ
);

    localparam int TW = $clog2(PHYS_REG_SZ);
    localparam int CW = $clog2(FL_SZ) + 1;

    logic dispatch_req;
    logic [TW-1:0] dispatch_T;
    logic dispatch_valid;
    logic retire_valid;
    logic [TW-1:0] retire_Told;
    logic flush;
    logic [CW-1:0] count;

    modport master (
        output dispatch_req,
        output retire_valid,
        output retire_Told,
        output flush,
        input dispatch_T,
        input dispatch_valid,
        input count
    );

    modport slave (
        input dispatch_req,
        input retire_valid,
        input retire_Told,
        input flush,
        output dispatch_T,
        output dispatch_valid,
        output count
    );

endinterface

// File: rtl/free_list_ptr_inc.sv
// Wrap-around increment for a ring pointer of DEPTH entries.
// Handles non-power-of-two depths explicitly.
module free_list_ptr_inc #(
    parameter int DEPTH = 32,
    localparam int W = $clog2(DEPTH)
) (
    input  logic [W-1:0] ptr,
    output logic [W-1:0] ptr_inc
);

    assign ptr_inc = (ptr == W'(DEPTH - 1))
                   ? '0 : ptr + 1'b1;

endmodule

// File: rtl/free_list.sv
// Circular free list of physical tags with an architectural head
// so a flush hands back every in-flight tag in one cycle.
module free_list
    import free_list_pkg::*;
#(
    parameter int PHYS_REG_SZ = free_list_pkg::PHYS_REG_SZ,
    parameter int ARCH_REG_SZ = free_list_pkg::ARCH_REG_SZ,
    parameter int FL_SZ = PHYS_REG_SZ - ARCH_REG_SZ
) (
    input logic clock,
    input logic reset,
    free_list_if.slave fl
);

    localparam int TW = $clog2(PHYS_REG_SZ);
    localparam int PW = $clog2(FL_SZ);
    localparam int CW = PW + 1;

    logic [TW-1:0] tbl [FL_SZ];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] arch_head;
    logic [PW-1:0] head_inc;
    logic [PW-1:0] tail_inc;
    logic [PW-1:0] arch_inc;
    logic [PW-1:0] arch_head_next;
    logic [CW-1:0] count;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic overflow;

    free_list_ptr_inc #(.DEPTH(FL_SZ)) u_head_inc (
        .ptr     (head),
        .ptr_inc (head_inc)
    );

    free_list_ptr_inc #(.DEPTH(FL_SZ)) u_tail_inc (
        .ptr     (tail),
        .ptr_inc (tail_inc)
    );

    free_list_ptr_inc #(.DEPTH(FL_SZ)) u_arch_inc (
        .ptr     (arch_head),
        .ptr_inc (arch_inc)
    );

    assign empty = (count == '0);
    assign full  = (count == CW'(FL_SZ));
    assign pop   = fl.dispatch_req && !empty && !fl.flush;

    // A same-cycle pop frees a slot, so only an idle full list overflows.
    assign overflow = fl.retire_valid && full && !pop && !fl.flush;
    assign push     = fl.retire_valid && !overflow;

    assign arch_head_next = push ? arch_inc : arch_head;

    assign fl.dispatch_T     = tbl[head];
    assign fl.dispatch_valid = !empty;
    assign fl.count          = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            arch_head <= '0;
            count     <= CW'(FL_SZ);
            for (int i = 0; i < FL_SZ; i++) begin
                tbl[i] <= TW'(ARCH_REG_SZ + i);
            end
        end else begin
            if (push) begin
                tbl[tail] <= fl.retire_Told;
                tail      <= tail_inc;
            end
            arch_head <= arch_head_next;
            if (fl.flush) begin
                head  <= arch_head_next;
                count <= CW'(FL_SZ);
            end else begin
                if (pop) begin
                    head <= head_inc;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!overflow)
            else $warning("free_list: retire while full, push dropped");
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed and random checks of free_list against a queue model
// of free tags plus the ordered list of uncommitted dispatches.
module tb_free_list;
    import free_list_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    free_list_if fl ();

    free_list dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    int q[$];
    int infl[$];
    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(
        input string tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        infl.delete();
        for (int i = 0; i < FL_SZ; i++) begin
            q.push_back(ARCH_REG_SZ + i);
        end
    endtask

    task automatic model_step(
        input bit req,
        input bit rv,
        input int told,
        input bit fls
    );
        int t;
        if (req && q.size() > 0 && !fls) begin
            t = q.pop_front();
            infl.push_back(t);
        end
        if (rv && !(q.size() == FL_SZ && !fls)) begin
            q.push_back(told);
            if (infl.size() > 0) begin
                void'(infl.pop_front());
            end
        end
        if (fls) begin
            for (int i = infl.size() - 1; i >= 0; i--) begin
                q.push_front(infl[i]);
            end
            infl.delete();
        end
    endtask

    task automatic step(
        input bit req,
        input bit rv,
        input int told,
        input bit fls,
        input bit rst = 1'b0
    );
        fl.dispatch_req = req;
        fl.retire_valid = rv;
        fl.retire_Told  = tag_t'(told);
        fl.flush        = fls;
        reset           = rst;
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else begin
            model_step(req, rv, told, fls);
        end
        #1;
        chk("count", 32'(fl.count), 32'(q.size()));
        chk("valid", 32'(fl.dispatch_valid),
            32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("dispatch_T", 32'(fl.dispatch_T), 32'(q[0]));
        end
    endtask

    initial begin
        bit req;
        bit rv;
        bit fls;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("reset_T", 32'(fl.dispatch_T), 32);
        chk("reset_count", 32'(fl.count), 32);

        for (int i = 0; i < FL_SZ; i++) begin
            chk("drain_T", 32'(fl.dispatch_T), 32'(32 + i));
            step(1, 0, 0, 0);
        end
        chk("empty_valid", 32'(fl.dispatch_valid), 0);
        step(1, 0, 0, 0);
        chk("empty_count", 32'(fl.count), 0);

        step(1, 1, 5, 0);
        chk("nobypass_T", 32'(fl.dispatch_T), 5);
        chk("nobypass_count", 32'(fl.count), 1);

        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 7, 0);
        end
        chk("wrap_T", 32'(fl.dispatch_T), 7);

        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
        end
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, k, 0);
        end
        step(0, 0, 0, 1);
        chk("flush_T", 32'(fl.dispatch_T), 35);
        for (int i = 0; i < FL_SZ; i++) begin
            step(1, 0, 0, 0);
        end

        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
        end
        step(1, 1, 9, 1);
        chk("flush_ret_T", 32'(fl.dispatch_T), 33);
        for (int i = 0; i < FL_SZ; i++) begin
            step(1, 0, 0, 0);
        end

        step(0, 0, 0, 0, 1);
        step(0, 1, 20, 0);
        chk("ovf_T", 32'(fl.dispatch_T), 32);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
        end
        step(1, 1, 3, 1, 1);
        chk("midreset_T", 32'(fl.dispatch_T), 32);

        for (int i = 0; i < 600; i++) begin
            req = ($urandom_range(3, 0) != 0);
            rv  = (infl.size() > 0) &&
                  ($urandom_range(2, 0) == 0);
            fls = ($urandom_range(24, 0) == 0);
            step(req, rv, int'($urandom_range(63, 0)), fls);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical-register tags for the R10K-style rename path. Dispatch pops one tag (the new `T`) per cycle. Retire pushes back the `Told` released by the ROB head instruction. An architectural head pointer tracks committed pops, so a pipeline flush returns every in-flight tag in one cycle. It is the supply end of the tag loop whose consumer end is the ROB's retire output.

## Interface
Parameters:
- `PHYS_REG_SZ`, default 64: number of physical registers. `TAG` width is `$clog2(PHYS_REG_SZ)`.
- `ARCH_REG_SZ`, default 32: number of architectural registers.
- `FL_SZ`, default `PHYS_REG_SZ-ARCH_REG_SZ` (32): free-list capacity.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `dispatch_req`, in, 1: dispatch consumes a tag this cycle.
- `dispatch_T`, out, `TAG`: tag at head. Combinational from head.
- `dispatch_valid`, out, 1: `count != 0`. Combinational.
- `retire_valid`, in, 1: ROB head retires this cycle.
- `retire_Told`, in, `TAG`: tag freed by the retiring instruction.
- `flush`, in, 1: squash all in-flight instructions.
- `count`, out, `$clog2(FL_SZ)+1`: number of free tags held.

## Operation
- State:
  - `table[FL_SZ]` of `TAG`.
  - `head`, `tail`, `arch_head`: each `$clog2(FL_SZ)` bits; wrap `FL_SZ-1 -> 0`.
  - `count`.
- Reset:
  - `table[i] = ARCH_REG_SZ+i` (tags 32..63).
  - `head = tail = arch_head = 0`.
  - `count = FL_SZ`.
  - Outputs after reset: `dispatch_valid=1`, `dispatch_T=32`, `count=32`.
- Pop: `pop = dispatch_req && dispatch_valid && !flush`. On pop, `head` advances by 1.
  - `dispatch_req` while empty is ignored: no state change.
  - The requester must stall on `!dispatch_valid`.
- Push: on `retire_valid`, `table[tail] <= retire_Told`, then `tail` and `arch_head` each advance by 1.
  - Retire also commits the oldest in-flight pop, so `arch_head` tracks `head` as it stood at the oldest unretired dispatch.
- Count: `count_next = count + push - pop` in the normal case.
  - Simultaneous pop and push: `count` unchanged, both pointers move.
- No bypass: when `count==0`, a same-cycle push does not make `dispatch_valid` high. The pushed tag is available the next cycle.
- Flush (highest priority for `head` and `count`):
  - `head <= arch_head_next`, where `arch_head_next` includes this cycle's retire increment.
  - `count <= FL_SZ`.
  - Pop is suppressed. A same-cycle push is still written, and `tail`/`arch_head` still advance.
- Overflow: a push when `count==FL_SZ` without flush is a protocol violation. Assert it in simulation. The RTL drops the push; no pointer moves.
- Reset has priority over flush, pop and push. Reset mid-operation discards all state and reloads the initial table.

## Timing
- `dispatch_T` and `dispatch_valid` are combinational from registered state. Zero-latency read; pop commits at the `clock` edge.
- A pushed tag reappears at `dispatch_T` only after all older entries have been popped, and no earlier than the cycle after the push.
- Flush takes effect at the edge. The next cycle shows `dispatch_T = table[arch_head_next]` and `count = FL_SZ`.
- All updates happen on `posedge clock`; there are no asynchronous paths.

## Structure
- The `TAG` typedef and the constants `PHYS_REG_SZ`, `ARCH_REG_SZ` and `FL_SZ` live in `sys_defs.svh`, shared with the ROB and map table.
- Add a free-list packet struct `{TAG T; logic valid;}` to `sys_defs.svh` for the dispatch stage.
- One small sub-module is natural: `ptr_inc`, a combinational wrap-around increment, instantiated for `head`, `tail` and `arch_head`.
- Single module otherwise; no memory macro.

## Test plan
- Reset, then 32 consecutive `dispatch_req` -> `dispatch_T` 32,33,...,63. Then `dispatch_valid=0` and `count=0`. A 33rd request leaves state unchanged.
- From empty, `retire_valid` with `Told=5` plus `dispatch_req` in the same cycle -> no pop that cycle. Next cycle `dispatch_valid=1`, `dispatch_T=5`, `count=1`.
- From reset, pop and push `Told=7` every cycle for 40 cycles -> `count` stays 32, pointers wrap past 31, and `dispatch_T` after cycle 32 is 7.
- From reset, pop 10 and retire 3 (`Told` 1,2,3), then `flush` -> `head=3`, `count=32`. Next `dispatch_T=35`. Tags 1,2,3 reside at table indices 0..2.
- `flush` with simultaneous `retire_valid` (`Told=9`) and `dispatch_req` -> `head=arch_head+1`, `count=32`, 9 written at `tail`, and no pop occurs.
- Push while `count=32` -> assertion fires and state is unchanged. Then `reset` mid-sequence -> state returns to initial values (`dispatch_T=32`, `count=32`).
